// File: rtl/wav_recorder.sv
// Decimating audio capture: arms on a pulse, starts on a level trigger, then streams one
// sample per prescaler tick into the sample RAM write port until full or stopped.
module wav_recorder #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int DIV    = 2177,
  parameter int THRESH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] audio_in,
  input  logic              arm,
  input  logic              stop,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  output logic [ADDR_W:0]   length,
  output logic              armed,
  output logic              recording,
  output logic              done
);

  localparam int PW = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [PW-1:0]     DIV_P     = PW'(DIV);
  localparam logic [DATA_W-1:0] MID       = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W:0]   THR       = (DATA_W+1)'(THRESH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP, S_DONE} state_t;

  function automatic logic [DATA_W-1:0] abs_dev(input logic [DATA_W-1:0] s);
    return (s >= MID) ? (s - MID) : (MID - s);
  endfunction

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [DATA_W-1:0] ram_d_q, ram_d_d;
  logic              armed_q, rec_q, done_q;
  logic              tick, trig;
  logic [PW-1:0]     presc_nxt;

  assign tick      = (presc_q == DIV_P);
  assign trig      = ({1'b0, abs_dev(audio_in)} >= THR);
  assign presc_nxt = tick ? '0 : presc_q + PW'(1);

  // Stop outranks tick, tick outranks arm; outputs are registered so the write strobe
  // appears the cycle after the tick edge that sampled audio_in.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    addr_d  = addr_q;
    len_d   = len_q;
    we_d    = 1'b0;
    ram_a_d = ram_a_q;
    ram_d_d = ram_d_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        presc_d = '0;
        if (arm) begin
          state_d = S_WAIT;
          addr_d  = '0;
          len_d   = '0;
        end
      end
      S_WAIT: begin
        presc_d = presc_nxt;
        if (stop) begin
          state_d = S_IDLE;
          presc_d = '0;
        end else if (tick && trig) begin
          we_d    = 1'b1;
          ram_a_d = addr_q;
          ram_d_d = audio_in;
          addr_d  = addr_q + ADDR_W'(1);
          len_d   = len_q + (ADDR_W+1)'(1);
          state_d = S_CAP;
        end
      end
      S_CAP: begin
        presc_d = presc_nxt;
        if (stop) begin
          state_d = S_DONE;
          presc_d = '0;
        end else if (tick) begin
          we_d    = 1'b1;
          ram_a_d = addr_q;
          ram_d_d = audio_in;
          addr_d  = addr_q + ADDR_W'(1);
          len_d   = len_q + (ADDR_W+1)'(1);
          if (addr_q == ADDR_LAST) begin
            state_d = S_DONE;
            presc_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      ram_a_q <= '0;
      ram_d_q <= '0;
      armed_q <= 1'b0;
      rec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      we_q    <= we_d;
      ram_a_q <= ram_a_d;
      ram_d_q <= ram_d_d;
      armed_q <= (state_d == S_WAIT);
      rec_q   <= (state_d == S_CAP);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_d     = ram_d_q;
  assign ram_we    = we_q;
  assign length    = len_q;
  assign armed     = armed_q;
  assign recording = rec_q;
  assign done      = done_q;

endmodule

// File: tb/tb_wav_recorder.sv
// Directed bench for wav_recorder: small RAM (16 samples), DIV=3, plus a THRESH=0 instance.
module tb_wav_recorder;

  logic       clk = 1'b0;
  logic       reset_n, arm, stop, arm0, stop0;
  logic [7:0] ain, ain0;
  logic [3:0] ram_a, ram_a0;
  logic [7:0] ram_d, ram_d0;
  logic       ram_we, ram_we0;
  logic [4:0] length, length0;
  logic       armed, recording, done, armed0, recording0, done0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int arm_c;
  int wq_a[$], wq_d[$], wq_c[$];
  int w0_a[$], w0_d[$], w0_c[$];

  always #5 clk = ~clk;

  wav_recorder #(.ADDR_W(4), .DATA_W(8), .DIV(3), .THRESH(16)) dut (
    .clk(clk), .reset_n(reset_n), .audio_in(ain), .arm(arm), .stop(stop),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .length(length),
    .armed(armed), .recording(recording), .done(done)
  );

  wav_recorder #(.ADDR_W(4), .DATA_W(8), .DIV(3), .THRESH(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .audio_in(ain0), .arm(arm0), .stop(stop0),
    .ram_a(ram_a0), .ram_d(ram_d0), .ram_we(ram_we0), .length(length0),
    .armed(armed0), .recording(recording0), .done(done0)
  );

  // Write log, sampled just after each rising edge; cyc is the number of edges seen.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (ram_we === 1'b1) begin
      wq_a.push_back(int'(ram_a));
      wq_d.push_back(int'(ram_d));
      wq_c.push_back(cyc);
    end
    if (ram_we0 === 1'b1) begin
      w0_a.push_back(int'(ram_a0));
      w0_d.push_back(int'(ram_d0));
      w0_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic clr();
    wq_a.delete();
    wq_d.delete();
    wq_c.delete();
  endtask

  task automatic wait_wr(input int n, input int lim, input string tag);
    int k = 0;
    while (wq_a.size() < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(wq_a.size() >= n), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; arm = 1'b0; stop = 1'b0; ain = 8'h80;
    arm0 = 1'b0; stop0 = 1'b0; ain0 = 8'h80;

    // 1: reset held while arm toggles and audio moves
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      arm = ~arm;
      ain = 8'($urandom);
      @(negedge clk);
      chk("reset_outputs", {11'd0, ram_a, ram_d, ram_we, length, armed, recording, done}, 32'd0);
    end
    arm = 1'b0;
    chk("reset_no_we", wq_a.size(), 0);
    reset_n = 1'b1;
    cyc_n(2);
    chk("idle_after_reset", {armed, recording, done}, 3'b000);

    // 2: sub-threshold audio does not trigger, 0x95 and 0x70 do
    clr();
    ain = 8'h85;
    pulse_arm();
    chk("armed_after_arm", armed, 1'b1);
    cyc_n(40);
    chk("no_write_below_thresh", wq_a.size(), 0);
    chk("still_armed", armed, 1'b1);
    ain = 8'h95;
    wait_wr(1, 8, "trig95_timeout");
    chk("trig95_addr", ram_a, 4'd0);
    chk("trig95_data", ram_d, 8'h95);
    chk("trig95_len", length, 5'd1);
    chk("trig95_rec", recording, 1'b1);
    pulse_stop();
    chk("trig95_done", {done, recording}, 2'b10);

    clr();
    ain = 8'h70;
    pulse_arm();
    wait_wr(1, 8, "trig70_timeout");
    chk("trig70_addr", ram_a, 4'd0);
    chk("trig70_data", ram_d, 8'h70);
    chk("trig70_len", length, 5'd1);
    pulse_stop();

    // 3: full recording with a ramp
    clr();
    ain = 8'h90;
    pulse_arm();
    for (int k = 0; k < 80; k++) begin
      ain = 8'h90 + 8'(wq_a.size());
      @(negedge clk);
    end
    chk("full_count", wq_a.size(), 16);
    for (int i = 0; i < 16 && i < wq_a.size(); i++) begin
      chk($sformatf("full_addr%0d", i), wq_a[i], i);
      chk($sformatf("full_data%0d", i), wq_d[i], 32'h90 + i);
      if (i > 0) chk($sformatf("full_space%0d", i), wq_c[i] - wq_c[i-1], 4);
    end
    chk("full_done", {done, recording, armed}, 3'b100);
    chk("full_len", length, 5'd16);
    cyc_n(20);
    chk("full_no_17th", wq_a.size(), 16);

    // 4: early stop between ticks, then on a tick edge
    clr();
    ain = 8'hC0;
    pulse_arm();
    wait_wr(5, 60, "stop_a_timeout");
    pulse_stop();
    cyc_n(12);
    chk("stop_a_done", {done, recording}, 2'b10);
    chk("stop_a_len", length, 5'd5);
    chk("stop_a_count", wq_a.size(), 5);

    clr();
    pulse_arm();
    wait_wr(5, 60, "stop_b_timeout");
    cyc_n(3);
    pulse_stop();
    cyc_n(12);
    chk("stop_b_done", done, 1'b1);
    chk("stop_b_len", length, 5'd5);
    chk("stop_b_count", wq_a.size(), 5);

    // 5: reset mid-capture, re-arm from DONE, arm ignored while capturing
    clr();
    pulse_arm();
    wait_wr(3, 40, "midrst_timeout");
    reset_n = 1'b0;
    cyc_n(2);
    chk("midrst_outputs", {11'd0, ram_a, ram_d, ram_we, length, armed, recording, done}, 32'd0);
    reset_n = 1'b1;
    cyc_n(8);
    chk("midrst_idle", {armed, recording, done}, 3'b000);
    chk("midrst_no_more", wq_a.size(), 3);

    clr();
    pulse_arm();
    wait_wr(2, 40, "rearm_pre_timeout");
    pulse_stop();
    chk("rearm_pre_len", length, 5'd2);
    chk("rearm_pre_done", done, 1'b1);
    clr();
    pulse_arm();
    chk("rearm_len_clear", length, 5'd0);
    chk("rearm_flags", {armed, done}, 2'b10);
    wait_wr(1, 8, "rearm_first_timeout");
    pulse_arm();
    chk("arm_in_cap_rec", recording, 1'b1);
    chk("arm_in_cap_len", length, 5'd1);
    wait_wr(3, 20, "rearm_three_timeout");
    for (int i = 0; i < 3 && i < wq_a.size(); i++)
      chk($sformatf("rearm_addr%0d", i), wq_a[i], i);
    chk("rearm_len3", length, 5'd3);
    pulse_stop();

    // 6: THRESH=0 instance writes on the first tick after arm
    ain0 = 8'h80;
    arm0 = 1'b1;
    arm_c = cyc + 1;
    @(negedge clk);
    arm0 = 1'b0;
    cyc_n(6);
    chk("t0_count", w0_a.size(), 1);
    if (w0_a.size() > 0) begin
      chk("t0_latency", w0_c[0] - arm_c, 4);
      chk("t0_addr", w0_a[0], 0);
      chk("t0_data", w0_d[0], 32'h80);
    end
    chk("t0_rec", recording0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
